oam_dma: RTL and testbench
==========================

Name: oam_dma

Overview:
- Sprite DMA engine sitting on the CPU bus directly upstream of the ppu OAM port.
- A CPU write to $4014 with page P makes the block hijack the bus for 513/514 cpu_clk cycles.
- During the hijack it copies CPU memory $P00–$PFF byte-by-byte into PPU register $2004 (OAMDATA).
- The ppu OAM write path advances oam_addr itself; this block only drives bus cycles.

Parameters:
- DMA_REG, 16'h4014, CPU address that triggers a transfer.
- OAMDATA_REG, 16'h2004, destination address driven on every write cycle.
- XFER_LEN, 256, bytes per transfer; fixed power of two, counter width = $clog2(XFER_LEN).

Ports:
- cpu_clk  in  1  single clock for the whole block.
- reset  in  1  asynchronous, active-low reset.
- bus_addr  in  16  CPU-driven address, snooped while idle.
- bus_din  in  8  CPU-driven write data, snooped while idle.
- bus_wr  in  1  bus direction: 1 = read cycle, 0 = write cycle (codebase bus polarity).
- odd_or_even  in  1  CPU cycle parity, 1 = odd cycle.
- mem_rdata  in  8  read data returned by CPU memory for the current hijacked read cycle.
- dma_hijack  out  1  high while the block owns the bus; CPU halted, bus mux selects dma_* signals.
- dma_addr  out  16  hijacked bus address.
- dma_dout  out  8  hijacked bus write data.
- dma_wr  out  1  hijacked bus direction, same polarity as bus_wr.
- dma_busy  out  1  mirrors dma_hijack; used for status and debug.

Behaviour:
- Reset values (reset low, takes effect immediately):
  - state = IDLE, dma_hijack = 0, dma_addr = 16'h0000, dma_dout = 8'h00, dma_wr = 1, dma_busy = 0.
  - page and count registers cleared.
- Trigger, in IDLE only: bus_addr == DMA_REG && bus_wr == 0 at a cpu_clk edge.
  - Latch page <= bus_din and count <= 0.
  - Go to HALT; dma_hijack rises in the next cycle (1-cycle latency).
- All outputs are registered.
- States:
  - IDLE: hijack low; snoop the bus for a trigger.
  - HALT: one dummy cycle; dma_addr = DMA_REG, dma_wr = 1.
    - If odd_or_even == 1 in HALT, go to ALIGN; otherwise go to READ.
  - ALIGN: one extra dummy cycle with the same outputs as HALT, then go to READ.
  - READ: dma_addr = {page, count}, dma_wr = 1.
    - mem_rdata is sampled at the edge that ends READ into data_q.
    - Then go to WRITE.
  - WRITE: dma_addr = OAMDATA_REG, dma_wr = 0, dma_dout = data_q.
    - count increments at the edge that ends WRITE.
    - If count == XFER_LEN-1 before the increment, go to IDLE; otherwise go to READ.
- Totals: 1 + 512 = 513 hijacked cycles for an even start, 514 for an odd start.
- Count wraps 255 -> 0 on the final increment. Source addresses never cross the page: $PFF is followed by termination, not $(P+1)00.
- Page $20–$3F is legal. The engine reads PPU registers as ordinary bus reads; no special-casing.
- Writes to DMA_REG while not in IDLE are ignored. The CPU is halted, so only a bus-mux fault can produce one; no retrigger, no page change.
- Any other bus traffic while IDLE is ignored.
- Reset asserted mid-transfer: abort immediately.
  - The partial OAM contents written so far remain in the ppu.
  - The first trigger after reset starts a fresh transfer at count 0.
- In IDLE the dma_addr, dma_dout and dma_wr outputs hold their reset values; they are don't-care to the bus mux.

Optional Feature:
- Macro: OAM_DMA_ALIGN_EN.
- Defined: odd_or_even is honoured in HALT. An odd start inserts ALIGN, for 514 total cycles.
- Undefined: ALIGN state is compiled out and odd_or_even is unused. Every transfer is exactly 513 cycles.

Decomposition:
- Shared package nes_bus_pkg holds:
  - address constants: DMA_REG, OAMDATA_REG, PPU register base $2000;
  - the bus direction localparams BUS_RD = 1'b1, BUS_WR = 1'b0;
  - the enum oam_dma_state_t {IDLE, HALT, ALIGN, READ, WRITE}.
- No sub-module: one FSM plus page/count/data registers.

Test Plan:
- Even start, full transfer:
  - Stimulus: write $4014 = 8'h02 with odd_or_even = 0; memory model returns (addr[7:0] ^ 8'hA5).
  - Response: dma_hijack rises the next cycle and stays high exactly 513 cycles.
  - Response: 256 writes to $2004 carrying 8'hA5, 8'hA4, ..., last 8'h5A; reads at $0200..$02FF in order.
- Odd start: same write with odd_or_even = 1.
  - With OAM_DMA_ALIGN_EN defined: 514 hijacked cycles, first READ at cycle 3.
  - With it undefined: 513 cycles.
- Trigger snooping in IDLE:
  - Read cycle at $4014 (bus_wr = 1) -> no hijack.
  - Write at $4015 -> no hijack.
  - Write at $2004 -> no hijack, all outputs unchanged.
- Reset mid-transfer: pull reset low at count = 8'h40 -> in the same cycle dma_hijack = 0, dma_wr = 1, dma_addr = 0.
- Retrigger after reset: write $4014 = 8'h07 -> transfer starts at $0700.
- Back-to-back transfers:
  - Write $4014 = 8'hFF; after completion write $4014 = 8'h00.
  - Response: second transfer reads $0000–$00FF.
  - Response: final source address of the first transfer is $FFFF, with no wrap into $0000 inside the first transfer.

Source files
------------

// File: rtl/nes_bus_pkg.sv
// Shared CPU-bus definitions: register addresses, bus direction encoding
// and the sprite DMA state type.
package nes_bus_pkg;

  localparam logic [15:0] PPU_BASE    = 16'h2000;
  localparam logic [15:0] OAMDATA_REG = 16'h2004;
  localparam logic [15:0] DMA_REG     = 16'h4014;

  // The codebase's bus_wr is a direction flag: high means read.
  localparam logic BUS_RD = 1'b1;
  localparam logic BUS_WR = 1'b0;

  localparam int XFER_LEN = 256;

  typedef enum logic [2:0] {
    IDLE,
    HALT,
    ALIGN,
    READ,
    WRITE
  } oam_dma_state_t;

endpackage

// File: rtl/oam_dma_if.sv
// CPU-bus view of the sprite DMA engine: snooped CPU cycle, memory read
// data, and the hijacked bus outputs.
interface oam_dma_if;

  logic [15:0] bus_addr;
  logic [7:0]  bus_din;
  logic        bus_wr;
  logic        odd_or_even;
  logic [7:0]  mem_rdata;

  logic        dma_hijack;
  logic [15:0] dma_addr;
  logic [7:0]  dma_dout;
  logic        dma_wr;
  logic        dma_busy;

  modport master (
    input  bus_addr, bus_din, bus_wr, odd_or_even, mem_rdata,
    output dma_hijack, dma_addr, dma_dout, dma_wr, dma_busy
  );

  modport slave (
    output bus_addr, bus_din, bus_wr, odd_or_even, mem_rdata,
    input  dma_hijack, dma_addr, dma_dout, dma_wr, dma_busy
  );

endinterface

// File: rtl/oam_dma.sv
// Sprite DMA: a CPU write to DMA_REG copies page $P00-$PFF into OAMDATA.
// Define OAM_DMA_ALIGN_EN to insert the odd-cycle ALIGN dummy cycle.
module oam_dma
  import nes_bus_pkg::*;
#(
  parameter logic [15:0] DMA_REG     = nes_bus_pkg::DMA_REG,
  parameter logic [15:0] OAMDATA_REG = nes_bus_pkg::OAMDATA_REG,
  parameter int          XFER_LEN    = nes_bus_pkg::XFER_LEN
) (
  input  logic          cpu_clk,
  input  logic          reset,
  oam_dma_if.master     bus
);

  localparam int CNT_W = $clog2(XFER_LEN);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XFER_LEN - 1);

  oam_dma_state_t   state, state_nxt;
  logic [7:0]       page, page_nxt;
  logic [CNT_W-1:0] count, count_nxt;
  logic [7:0]       data_q, data_nxt;

  logic             hijack_q, hijack_nxt;
  logic [15:0]      addr_q, addr_nxt;
  logic [7:0]       dout_q, dout_nxt;
  logic             wr_q, wr_nxt;

  logic             trigger;

  assign trigger = (bus.bus_addr == DMA_REG) && (bus.bus_wr == BUS_WR);

  always_ff @(posedge cpu_clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      page     <= '0;
      count    <= '0;
      data_q   <= '0;
      hijack_q <= 1'b0;
      addr_q   <= 16'h0000;
      dout_q   <= 8'h00;
      wr_q     <= BUS_RD;
    end else begin
      state    <= state_nxt;
      page     <= page_nxt;
      count    <= count_nxt;
      data_q   <= data_nxt;
      hijack_q <= hijack_nxt;
      addr_q   <= addr_nxt;
      dout_q   <= dout_nxt;
      wr_q     <= wr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    page_nxt  = page;
    count_nxt = count;
    data_nxt  = data_q;

    case (state)
      IDLE: begin
        if (trigger) begin
          page_nxt  = bus.bus_din;
          count_nxt = '0;
          state_nxt = HALT;
        end
      end
      HALT: begin
`ifdef OAM_DMA_ALIGN_EN
        state_nxt = bus.odd_or_even ? ALIGN : READ;
`else
        state_nxt = READ;
`endif
      end
`ifdef OAM_DMA_ALIGN_EN
      ALIGN: state_nxt = READ;
`endif
      READ: begin
        data_nxt  = bus.mem_rdata;
        state_nxt = WRITE;
      end
      WRITE: begin
        count_nxt = count + 1'b1;
        state_nxt = (count == LAST_CNT) ? IDLE : READ;
      end
      default: state_nxt = IDLE;
    endcase

    // Outputs are decoded from the upcoming state so they register in
    // lockstep with it; the source address never carries into the page.
    hijack_nxt = 1'b0;
    addr_nxt   = 16'h0000;
    dout_nxt   = 8'h00;
    wr_nxt     = BUS_RD;

    case (state_nxt)
      HALT, ALIGN: begin
        hijack_nxt = 1'b1;
        addr_nxt   = DMA_REG;
      end
      READ: begin
        hijack_nxt = 1'b1;
        addr_nxt   = {page_nxt, 8'(count_nxt)};
      end
      WRITE: begin
        hijack_nxt = 1'b1;
        addr_nxt   = OAMDATA_REG;
        wr_nxt     = BUS_WR;
        dout_nxt   = data_nxt;
      end
      default: ;
    endcase
  end

  assign bus.dma_hijack = hijack_q;
  assign bus.dma_busy   = hijack_q;
  assign bus.dma_addr   = addr_q;
  assign bus.dma_dout   = dout_q;
  assign bus.dma_wr     = wr_q;

endmodule

// File: tb/tb_oam_dma.sv
// Self-checking bench for oam_dma: randomized transfers compared cycle by
// cycle against a behavioural model of the hijacked bus sequence.
module tb_oam_dma;
  import nes_bus_pkg::*;

`ifdef OAM_DMA_ALIGN_EN
  localparam bit ALIGN_ON = 1'b1;
`else
  localparam bit ALIGN_ON = 1'b0;
`endif

  logic cpu_clk = 1'b0;
  logic reset   = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  oam_dma_if bus();

  oam_dma dut (
    .cpu_clk (cpu_clk),
    .reset   (reset),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] salt     = 8'hA5;
  logic [7:0] page_mix = 8'h00;

  function automatic logic [7:0] mem_fn(input logic [15:0] a,
                                        input logic [7:0] s,
                                        input logic [7:0] m);
    return a[7:0] ^ s ^ (a[15:8] & m);
  endfunction

  always_comb bus.mem_rdata = mem_fn(bus.dma_addr, salt, page_mix);

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int n_dummy(input bit odd);
    return (ALIGN_ON && odd) ? 2 : 1;
  endfunction

  // Expected {hijack, busy, wr, addr} for hijacked cycle k (k = 0 is the
  // first cycle with hijack high); cycles past the end are idle.
  function automatic logic [31:0] exp_ctl(input logic [7:0] page,
                                          input bit odd, input int k);
    int d;
    int j;
    d = n_dummy(odd);
    if (k < d) return {13'd0, 1'b1, 1'b1, BUS_RD, DMA_REG};
    j = k - d;
    if (j >= 2 * XFER_LEN) return {13'd0, 1'b0, 1'b0, BUS_RD, 16'h0000};
    if (j % 2 == 0) return {13'd0, 1'b1, 1'b1, BUS_RD, page, 8'(j / 2)};
    return {13'd0, 1'b1, 1'b1, BUS_WR, OAMDATA_REG};
  endfunction

  function automatic logic [31:0] obs_ctl();
    return {13'd0, bus.dma_hijack, bus.dma_busy, bus.dma_wr, bus.dma_addr};
  endfunction

  task automatic bus_idle();
    bus.bus_addr = 16'h0000;
    bus.bus_wr   = BUS_RD;
    bus.bus_din  = 8'h00;
  endtask

  task automatic trigger(input logic [7:0] page, input bit odd);
    @(negedge cpu_clk);
    bus.bus_addr    = DMA_REG;
    bus.bus_wr      = BUS_WR;
    bus.bus_din     = page;
    bus.odd_or_even = odd;
    @(negedge cpu_clk);
    bus_idle();
  endtask

  task automatic run_xfer(input logic [7:0] page, input bit odd,
                          input bit noise);
    int n;
    int d;
    int j;
    int seen;
    d    = n_dummy(odd);
    n    = d + 2 * XFER_LEN;
    seen = 0;
    trigger(page, odd);
    for (int k = 0; k < n + 2; k++) begin
      check_eq($sformatf("ctl p%02h k%0d", page, k), obs_ctl(),
               exp_ctl(page, odd, k));
      if (bus.dma_hijack) seen++;
      j = k - d;
      if (k >= d && j < 2 * XFER_LEN && (j % 2) == 1)
        check_eq($sformatf("dout p%02h k%0d", page, k), {24'd0, bus.dma_dout},
                 {24'd0, mem_fn({page, 8'(j / 2)}, salt, page_mix)});
      if (k >= n)
        check_eq($sformatf("idle dout p%02h", page), {24'd0, bus.dma_dout}, 32'd0);
      if (noise && k < n - 1) begin
        bus.bus_addr = ($urandom_range(0, 1) == 1) ? DMA_REG : 16'($urandom);
        bus.bus_wr   = 1'($urandom);
        bus.bus_din  = 8'($urandom);
        if (k >= 1) bus.odd_or_even = 1'($urandom);
      end else begin
        bus_idle();
      end
      @(negedge cpu_clk);
    end
    check_eq($sformatf("len p%02h", page), seen, n);
  endtask

  task automatic snoop(input logic [15:0] a, input logic wr);
    @(negedge cpu_clk);
    bus.bus_addr = a;
    bus.bus_wr   = wr;
    bus.bus_din  = 8'h5C;
    @(negedge cpu_clk);
    bus_idle();
    for (int k = 0; k < 2; k++) begin
      check_eq($sformatf("snoop %04h/%0d", a, wr), obs_ctl(),
               {13'd0, 1'b0, 1'b0, BUS_RD, 16'h0000});
      check_eq($sformatf("snoop dout %04h", a), {24'd0, bus.dma_dout}, 32'd0);
      @(negedge cpu_clk);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_idle();
    bus.odd_or_even = 1'b0;

    #12;
    check_eq("reset ctl", obs_ctl(), {13'd0, 1'b0, 1'b0, BUS_RD, 16'h0000});
    check_eq("reset dout", {24'd0, bus.dma_dout}, 32'd0);
    @(negedge cpu_clk);
    reset = 1'b1;
    @(negedge cpu_clk);

    // Even start, memory returns addr[7:0] ^ A5.
    salt = 8'hA5; page_mix = 8'h00;
    run_xfer(8'h02, 1'b0, 1'b0);

    // Odd start.
    salt = 8'($urandom); page_mix = 8'($urandom);
    run_xfer(8'h02, 1'b1, 1'b0);

    snoop(DMA_REG, BUS_RD);
    snoop(16'h4015, BUS_WR);
    snoop(OAMDATA_REG, BUS_WR);

    // Abort in the READ cycle of count $40.
    trigger(8'h03, 1'b0);
    for (int k = 0; k < n_dummy(1'b0) + 2 * 8'h40; k++) @(negedge cpu_clk);
    check_eq("pre-abort addr", obs_ctl(), {13'd0, 1'b1, 1'b1, BUS_RD, 16'h0340});
    reset = 1'b0;
    #1;
    check_eq("abort ctl", obs_ctl(), {13'd0, 1'b0, 1'b0, BUS_RD, 16'h0000});
    check_eq("abort dout", {24'd0, bus.dma_dout}, 32'd0);
    @(negedge cpu_clk);
    reset = 1'b1;
    @(negedge cpu_clk);
    check_eq("post-abort idle", obs_ctl(), {13'd0, 1'b0, 1'b0, BUS_RD, 16'h0000});

    run_xfer(8'h07, 1'b0, 1'b0);

    // Back-to-back: top page then page zero.
    run_xfer(8'hFF, 1'b0, 1'b0);
    run_xfer(8'h00, 1'b0, 1'b0);

    // PPU register page read as ordinary memory.
    run_xfer(8'h20, 1'b0, 1'b0);

    for (int r = 0; r < 4; r++) begin
      salt     = 8'($urandom);
      page_mix = 8'($urandom);
      run_xfer(8'($urandom), 1'($urandom), 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
